pn_spread_ctrl: RTL and testbench

PN_SPREAD_CTRL -- requirements
Module: pn_spread_ctrl

---
 rtl/pn_spread_ctrl.sv | 142 ++++++++++++++
 tb/tb_pn_spread_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pn_spread_ctrl.sv
// PN spreading controller: each data bit is XORed with a 127-chip m-sequence
// that restarts from the seed for every bit. One chip is emitted every CHIP_DIV clocks.
module pn_spread_ctrl #(
  parameter int CHIP_DIV       = 4,
  parameter int BITS_PER_FRAME = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  input  logic       seed_load,
  input  logic [6:0] seed,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic       bit_ready,
  output logic       chip_out,
  output logic       chip_valid,
  output logic       sym_start,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [6:0] SEED_DEF  = 7'b1000001;
  localparam logic [6:0] CHIP_LAST = 7'd126;
  localparam logic [7:0] DIV_LAST  = 8'(CHIP_DIV - 1);
  localparam logic [7:0] BIT_LAST  = 8'(BITS_PER_FRAME - 1);

  logic [2:0] state;
  logic [6:0] seed_reg;
  logic [6:0] pn;        // pn[0] = p1 ... pn[6] = p7
  logic       buf_full;
  logic       buf_bit;
  logic       cur_bit;
  logic [7:0] div_cnt;
  logic [6:0] chip_cnt;
  logic [7:0] bit_cnt;

  logic strobe;
  logic accept;

  // Feedback p7^p4^p3^p2 enters p1; all other stages shift up by one.
  function automatic logic [6:0] pn_advance(input logic [6:0] r);
    return {r[5:0], r[6] ^ r[3] ^ r[2] ^ r[1]};
  endfunction

  assign strobe     = (state == S_RUN) && (div_cnt == DIV_LAST) && !abort;
  assign bit_ready  = !buf_full && ((state == S_LOAD) || (state == S_WAIT) || (state == S_RUN));
  assign accept     = bit_valid && bit_ready;
  assign chip_valid = strobe;
  assign chip_out   = strobe & (cur_bit ^ pn[6]);
  assign sym_start  = strobe && (chip_cnt == 7'd0);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE) && !abort;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      seed_reg <= SEED_DEF;
      pn       <= SEED_DEF;
      buf_full <= 1'b0;
      buf_bit  <= 1'b0;
      cur_bit  <= 1'b0;
      div_cnt  <= 8'd0;
      chip_cnt <= 7'd0;
      bit_cnt  <= 8'd0;
      underrun <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (abort) begin
        // abort wins over start and drops any buffered bit
        state    <= S_IDLE;
        buf_full <= 1'b0;
      end else begin
        if (accept) begin
          buf_full <= 1'b1;
          buf_bit  <= bit_in;
        end
        case (state)
          S_IDLE: begin
            if (seed_load) seed_reg <= (seed == 7'd0) ? SEED_DEF : seed;
            if (start) state <= S_LOAD;
          end
          S_LOAD: begin
            pn       <= seed_reg;
            div_cnt  <= 8'd0;
            chip_cnt <= 7'd0;
            bit_cnt  <= 8'd0;
            state    <= S_WAIT;
          end
          S_WAIT: begin
            if (buf_full) begin
              cur_bit  <= buf_bit;
              buf_full <= 1'b0;
              div_cnt  <= 8'd0;
              state    <= S_RUN;
            end
          end
          S_RUN: begin
            if (div_cnt == DIV_LAST) begin
              div_cnt <= 8'd0;
              if (chip_cnt == CHIP_LAST) begin
                pn       <= seed_reg;
                chip_cnt <= 7'd0;
                if (bit_cnt == BIT_LAST) begin
                  state <= S_DONE;
                end else begin
                  bit_cnt <= bit_cnt + 8'd1;
                  // a buffered bit continues seamlessly; otherwise starve in WAIT
                  if (buf_full) begin
                    cur_bit  <= buf_bit;
                    buf_full <= 1'b0;
                  end else begin
                    state    <= S_WAIT;
                    underrun <= 1'b1;
                  end
                end
              end else begin
                pn       <= pn_advance(pn);
                chip_cnt <= chip_cnt + 7'd1;
              end
            end else begin
              div_cnt <= div_cnt + 8'd1;
            end
          end
          S_DONE: begin
            buf_full <= 1'b0;
            state    <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pn_spread_ctrl.sv
// Directed bench for pn_spread_ctrl with CHIP_DIV=4 and BITS_PER_FRAME=2.
module tb_pn_spread_ctrl;
  localparam int CD  = 4;
  localparam int BPF = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       seed_load = 1'b0;
  logic [6:0] seed = 7'd0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_ready, chip_out, chip_valid, sym_start, busy, done, underrun;

  int total = 0;
  int bad = 0;

  logic [126:0] ref0;
  logic [126:0] ref2a;

  pn_spread_ctrl #(.CHIP_DIV(CD), .BITS_PER_FRAME(BPF)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .seed_load(seed_load), .seed(seed), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .chip_out(chip_out), .chip_valid(chip_valid),
    .sym_start(sym_start), .busy(busy), .done(done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  function automatic int outs();
    return int'({chip_out, chip_valid, sym_start, bit_ready, busy, done, underrun});
  endfunction

  function automatic logic [126:0] pn_ref(input logic [6:0] s);
    logic [6:0]   r;
    logic [126:0] o;
    r = s;
    for (int i = 0; i < 127; i++) begin
      o[i] = r[6];
      r = {r[5:0], r[6] ^ r[3] ^ r[2] ^ r[1]};
    end
    return o;
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic wait_chip(output logic c, output logic s, output int dt);
    logic hit;
    hit = 1'b0;
    c = 1'b0;
    s = 1'b0;
    dt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      dt++;
      if (chip_valid) begin
        c = chip_out;
        s = sym_start;
        hit = 1'b1;
        break;
      end
    end
    if (!hit) chk("chip_timeout", int'(chip_valid), 1);
  endtask

  task automatic collect(input int n, output logic [253:0] st, output logic [253:0] sy,
                         output int gaperr);
    logic c, s;
    int   dt;
    st = '0;
    sy = '0;
    gaperr = 0;
    for (int i = 0; i < n; i++) begin
      wait_chip(c, s, dt);
      st[i] = c;
      sy[i] = s;
      if (i > 0 && dt != CD) gaperr++;
    end
  endtask

  task automatic offer_bit(input logic b);
    logic ok;
    ok = 1'b0;
    bit_in = b;
    bit_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (bit_ready) begin
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    bit_valid = 1'b0;
    if (!ok) chk("offer_timeout", int'(bit_ready), 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    logic [253:0] st, sy, st2, sy2;
    int g, uc, cvc, dn, dt;
    logic c, s;

    ref0  = pn_ref(7'b1000001);
    ref2a = pn_ref(7'h2A);

    // reset and idle
    repeat (2) @(negedge clk);
    chk("rst_outs", outs(), 0);
    reset_n = 1'b1;
    bit_valid = 1'b1;
    @(negedge clk);
    chk("idle_outs", outs(), 0);
    bit_valid = 1'b0;

    // two bits back-to-back: 0 then 1
    pulse_start();
    chk("load_busy", int'({busy, bit_ready}), 3);
    offer_bit(1'b0);
    offer_bit(1'b1);
    collect(254, st, sy, g);
    chk("bit0_first7", int'(st[6:0]), int'(7'b1000001));
    chk("bit1_first7", int'(st[133:127]), int'(7'b0111110));
    chk("chip127", int'(st[127]), int'(st[0] ^ 1'b1));
    chk("stream_a", $countones(st[126:0] ^ ref0) + $countones(st[253:127] ^ ~ref0), 0);
    chk("sym_count", $countones(sy), 2);
    chk("sym_pos", int'({sy[127], sy[0]}), 3);
    chk("gap_a", g, 0);
    @(negedge clk);
    chk("done_a", int'({done, busy}), 3);
    @(negedge clk);
    chk("idle_a", int'({done, busy, bit_ready}), 0);

    // second bit withheld: underrun, stall, resume
    pulse_start();
    offer_bit(1'b1);
    collect(127, st, sy, g);
    chk("stream_b0", $countones(st[126:0] ^ ~ref0), 0);
    @(negedge clk);
    chk("underrun_pulse", int'({underrun, busy, bit_ready, chip_valid}), 'he);
    uc = 0;
    cvc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      uc += int'(underrun);
      cvc += int'(chip_valid);
    end
    chk("underrun_once", uc, 0);
    chk("starved_chips", cvc, 0);
    offer_bit(1'b0);
    wait_chip(c, s, dt);
    chk("resume_lat", dt, CD);
    chk("resume_chip", int'({s, c}), 3);
    collect(126, st, sy, g);
    chk("stream_b1", $countones(st[125:0] ^ ref0[126:1]), 0);
    @(negedge clk);
    chk("done_b", int'(done), 1);
    @(negedge clk);

    // zero seed_load maps to default; seed_load while running is ignored
    seed = 7'd0;
    seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    pulse_start();
    offer_bit(1'b0);
    offer_bit(1'b0);
    collect(4, st, sy, g);
    chk("seed0_first4", int'(st[3:0]), int'(4'b0001));
    seed = 7'h2A;
    seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    collect(250, st2, sy2, g);
    chk("seed_run_stream", $countones(st[3:0] ^ ref0[3:0]) + $countones(st2[122:0] ^ ref0[126:4])
        + $countones(st2[249:123] ^ ref0), 0);
    @(negedge clk);
    chk("done_c", int'(done), 1);
    @(negedge clk);

    // non-default seed, abort at chip 50 with a bit buffered
    seed = 7'h2A;
    seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    pulse_start();
    offer_bit(1'b1);
    offer_bit(1'b0);
    collect(50, st, sy, g);
    chk("seed2a_stream", $countones(st[49:0] ^ ~ref2a[49:0]), 0);
    repeat (4) @(negedge clk);
    chk("pre_abort_cv", int'(chip_valid), 1);
    abort = 1'b1;
    #1;
    chk("abort_cv", int'(chip_valid), 0);
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle", int'({busy, done}), 0);
    dn = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      dn += int'(done);
    end
    chk("abort_no_done", dn, 0);
    pulse_start();
    chk("abort_buf_empty", int'(bit_ready), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_load", int'(busy), 0);

    // start and abort together
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort", int'(busy), 0);

    // asynchronous reset in the middle of a chip strobe
    seed = 7'd0;
    seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    pulse_start();
    offer_bit(1'b0);
    offer_bit(1'b1);
    collect(10, st, sy, g);
    chk("pre_rst_cv", int'(chip_valid), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst", outs(), 0);
    @(negedge clk);
    reset_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      dn += int'(done) + int'(busy);
    end
    chk("rst_no_done", dn, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
